hazard_fwd_scoreboard: RTL and testbench
========================================

// Module: hazard_fwd_scoreboard
// PURPOSE
//  Parametrised forwarding + hazard unit for the integer pipeline. Selects the nearest in-flight producer for
//  each EX source operand across FWD_STAGES post-EX stages, detects load-use hazards in ID, and tracks
//  outstanding writes of multi-cycle (long-latency) ops in a register scoreboard, stalling ID on RAW/WAW.
// PARAMETERS
//  ADDR_WIDTH  5   register address width (matches SYSTEM_DEF.vh)
//  NUM_REGS    32  architectural registers; x0 never forwarded, never tracked
//  NUM_SRC     2   source operands per instruction
//  FWD_STAGES  2   forwarding stages after EX; stage 1 = nearest (MEM), stage FWD_STAGES = farthest (WB)
//  LONG_MAX    4   max outstanding long ops (2..15)
// PORTS
//  clk           in   1                      clock, rising edge
//  rst_n         in   1                      reset, asynchronous, active-low
//  id_valid      in   1                      valid instruction in ID
//  id_rs_addr    in   NUM_SRC*ADDR_WIDTH     ID sources, src i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//  id_rs_used    in   NUM_SRC                ID source i actually read
//  id_rd_addr    in   ADDR_WIDTH             ID destination
//  id_reg_w      in   1                      ID writes rd
//  id_is_long    in   1                      ID instruction is a long op
//  ex_rs_addr    in   NUM_SRC*ADDR_WIDTH     EX sources (forwarding lookup)
//  ex_rd_addr    in   ADDR_WIDTH             EX destination
//  ex_reg_w      in   1                      EX writes rd
//  ex_is_load    in   1                      EX is a load
//  ex_is_long    in   1                      EX issues to long unit this cycle
//  ex_kill       in   1                      EX instruction squashed; no scoreboard effect
//  stg_rd_addr   in   FWD_STAGES*ADDR_WIDTH  destination per forwarding stage
//  stg_reg_w     in   FWD_STAGES             stage k writes rd (bit k-1)
//  lu_wb_valid   in   1                      long unit writes back this cycle
//  lu_wb_rd      in   ADDR_WIDTH             long unit writeback register
//  fwd_sel       out  NUM_SRC*SELW           SELW=$clog2(FWD_STAGES+1); 0=regfile, k=stage k
//  stall_id      out  1                      hold IF/ID, inject bubble into EX
//  sb_err        out  1                      sticky: lu_wb to non-busy reg or counter underflow
//  stall_cycles  out  32                     stall cycle count (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async, rst_n=0): busy[] all 0, outstanding=0, sb_err=0, stall_cycles=0; stall_id=0, fwd_sel=0 given idle inputs.
//  - fwd_sel (comb, 0 latency): per src, lowest k with stg_reg_w[k-1] && rd!=0 && rd==rs; none -> 0.
//    Nearest stage wins on multi-match (generalises old MEM-over-WB priority).
//  - Load-use: id_valid && ex_is_load && ex_reg_w && !ex_kill && ex_rd!=0 && match on any used ID src -> stall.
//  - Scoreboard RAW: any used ID src with busy[rs] -> stall. WAW: id_reg_w && busy[id_rd] -> stall.
//  - Structural: id_is_long && outstanding==LONG_MAX -> stall. stall_id = OR of above, gated by id_valid.
//  - Set: posedge where ex_is_long && ex_reg_w && !ex_kill && ex_rd!=0 -> busy[ex_rd]<=1, outstanding+1.
//  - Clear: posedge where lu_wb_valid -> busy[lu_wb_rd]<=0, outstanding-1. Stall releases cycle after clear
//    (regfile is write-first; no long-unit forwarding path).
//  - Same-cycle set+clear of same reg: set wins (busy stays 1); outstanding unchanged.
//  - lu_wb_valid with busy[rd]==0 or outstanding==0: sb_err<=1, no decrement below 0.
//  - Stall combinationally depends only on current inputs and registered state; no comb loop via stall_id.
// CONFIGURATION
//  HAZ_PERF_CNT_EN defined: stall_cycles increments (saturating at 2^32-1) every cycle stall_id=1.
//  Not defined: counter not built, stall_cycles tied to 0; all other behaviour identical.
// STRUCTURE
//  - SYSTEM_DEF.vh: ADDR_WIDTH, forwarding select encodings (FWD_RF=0), LONG_MAX default.
//  - Sub-module hazard_scoreboard: busy[] vector, outstanding counter, sb_err; set/clear ports, busy lookup.
//  - Top: generate loops for fwd select per src and hazard compare; optional perf counter.
// TESTING
//  - Stage1 rd=5 w=1, stage2 rd=5 w=1, ex_rs1=5 -> fwd_sel src0=1; drop stage1 w -> 2; rd=0 -> 0.
//  - ex_is_load rd=7, ID rs2=7 used -> stall_id=1 one cycle; rs2 unused -> 0; ex_kill=1 -> 0.
//  - Long op rd=9 issued; ID rs1=9 stalls until cycle after lu_wb_valid rd=9, then stall_id=0.
//  - Issue 4 long ops (rd 1..4); ID id_is_long -> stall; one lu_wb -> stall drops next cycle.
//  - Same-cycle set rd=3 and lu_wb rd=3 -> busy[3]=1, outstanding unchanged; lu_wb rd=6 not busy -> sb_err=1.
//  - rst_n low mid-stall with 3 pending -> busy cleared, stall_id=0 immediately; HAZ_PERF_CNT_EN: count resets to 0.

Source files
------------

// File: rtl/hazard_fwd_scoreboard_pkg.sv
// Shared constants for the forwarding / hazard / scoreboard unit.
package hazard_fwd_scoreboard_pkg;

    localparam int ADDR_WIDTH_DEF = 5;
    localparam int NUM_REGS_DEF   = 32;
    localparam int NUM_SRC_DEF    = 2;
    localparam int FWD_STAGES_DEF = 2;
    localparam int LONG_MAX_DEF   = 4;

    // Forwarding select value meaning "take the operand from the register file".
    localparam int FWD_RF = 0;

    // Outstanding-long-op counter width; wide enough for LONG_MAX up to 15.
    localparam int SB_CNT_W = 4;

endpackage

// File: rtl/hazard_scoreboard.sv
// Register scoreboard: one busy bit per architectural register for
// long-latency results in flight, an outstanding-op counter, and a sticky
// error flag raised by writebacks that have no matching pending write.
module hazard_scoreboard
    import hazard_fwd_scoreboard_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int NUM_REGS   = NUM_REGS_DEF,
    parameter int CNT_W      = SB_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  set_en,
    input  logic [ADDR_WIDTH-1:0] set_rd,
    input  logic                  clr_en,
    input  logic [ADDR_WIDTH-1:0] clr_rd,
    output logic [NUM_REGS-1:0]   busy,
    output logic [CNT_W-1:0]      outstanding,
    output logic                  sb_err
);

    logic                clr_ok;
    logic [NUM_REGS-1:0] busy_nxt;
    logic [CNT_W-1:0]    cnt_nxt;

    // A writeback only retires something if that register is pending and the counter is non-zero.
    assign clr_ok = clr_en && busy[clr_rd] && (outstanding != '0);

    // Next busy vector: clear first so a same-cycle set of the same register wins; x0 never tracked.
    always_comb begin
        busy_nxt = busy;
        if (clr_ok) begin
            busy_nxt[clr_rd] = 1'b0;
        end
        if (set_en) begin
            busy_nxt[set_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    // Next outstanding count: set and clear together cancel out; never wraps in either direction.
    always_comb begin
        cnt_nxt = outstanding;
        if (set_en && !clr_ok && (outstanding != '1)) begin
            cnt_nxt = outstanding + CNT_W'(1);
        end else if (!set_en && clr_ok) begin
            cnt_nxt = outstanding - CNT_W'(1);
        end
    end

    // Scoreboard state, with a sticky error on any unmatched writeback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy        <= '0;
            outstanding <= '0;
            sb_err      <= 1'b0;
        end else begin
            busy        <= busy_nxt;
            outstanding <= cnt_nxt;
            if (clr_en && !clr_ok) begin
                sb_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/hazard_fwd_scoreboard.sv
// Forwarding select, load-use detection and long-op scoreboard stalls for
// the integer pipeline. Optional stall-cycle performance counter is built
// when the macro HAZ_PERF_CNT_EN is defined; otherwise stall_cycles is 0.
module hazard_fwd_scoreboard
    import hazard_fwd_scoreboard_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int NUM_REGS   = NUM_REGS_DEF,
    parameter int NUM_SRC    = NUM_SRC_DEF,
    parameter int FWD_STAGES = FWD_STAGES_DEF,
    parameter int LONG_MAX   = LONG_MAX_DEF,
    parameter int SELW       = $clog2(FWD_STAGES + 1)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             id_valid,
    input  logic [NUM_SRC*ADDR_WIDTH-1:0]    id_rs_addr,
    input  logic [NUM_SRC-1:0]               id_rs_used,
    input  logic [ADDR_WIDTH-1:0]            id_rd_addr,
    input  logic                             id_reg_w,
    input  logic                             id_is_long,
    input  logic [NUM_SRC*ADDR_WIDTH-1:0]    ex_rs_addr,
    input  logic [ADDR_WIDTH-1:0]            ex_rd_addr,
    input  logic                             ex_reg_w,
    input  logic                             ex_is_load,
    input  logic                             ex_is_long,
    input  logic                             ex_kill,
    input  logic [FWD_STAGES*ADDR_WIDTH-1:0] stg_rd_addr,
    input  logic [FWD_STAGES-1:0]            stg_reg_w,
    input  logic                             lu_wb_valid,
    input  logic [ADDR_WIDTH-1:0]            lu_wb_rd,
    output logic [NUM_SRC*SELW-1:0]          fwd_sel,
    output logic                             stall_id,
    output logic                             sb_err,
    output logic [31:0]                      stall_cycles
);

    logic [NUM_REGS-1:0] busy;
    logic [SB_CNT_W-1:0] outstanding;
    logic                sb_set;
    logic                load_pending;
    logic [NUM_SRC-1:0]  lu_hit;
    logic [NUM_SRC-1:0]  raw_hit;
    logic                waw_hit;
    logic                struct_hit;

    // A live, non-squashed long op with a real destination reserves that register.
    assign sb_set = ex_is_long && ex_reg_w && !ex_kill && (ex_rd_addr != '0);

    hazard_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .CNT_W      (SB_CNT_W)
    ) u_sb (
        .clk         (clk),
        .rst_n       (rst_n),
        .set_en      (sb_set),
        .set_rd      (ex_rd_addr),
        .clr_en      (lu_wb_valid),
        .clr_rd      (lu_wb_rd),
        .busy        (busy),
        .outstanding (outstanding),
        .sb_err      (sb_err)
    );

    // The load in EX can only satisfy a consumer one cycle later, so any used match stalls ID.
    assign load_pending = ex_is_load && ex_reg_w && !ex_kill && (ex_rd_addr != '0);

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        logic [ADDR_WIDTH-1:0] ex_rs;
        logic [ADDR_WIDTH-1:0] id_rs;
        logic [SELW-1:0]       sel;

        assign ex_rs = ex_rs_addr[s*ADDR_WIDTH +: ADDR_WIDTH];
        assign id_rs = id_rs_addr[s*ADDR_WIDTH +: ADDR_WIDTH];

        // Scan farthest to nearest so the nearest matching producer overrides older ones.
        always_comb begin
            sel = SELW'(FWD_RF);
            for (int k = FWD_STAGES; k >= 1; k--) begin
                if (stg_reg_w[k-1] &&
                    (stg_rd_addr[(k-1)*ADDR_WIDTH +: ADDR_WIDTH] != '0) &&
                    (stg_rd_addr[(k-1)*ADDR_WIDTH +: ADDR_WIDTH] == ex_rs)) begin
                    sel = SELW'(k);
                end
            end
        end

        assign fwd_sel[s*SELW +: SELW] = sel;
        assign lu_hit[s]  = id_rs_used[s] && load_pending && (id_rs == ex_rd_addr);
        assign raw_hit[s] = id_rs_used[s] && busy[id_rs];
    end

    assign waw_hit    = id_reg_w && busy[id_rd_addr];
    assign struct_hit = id_is_long && (outstanding == SB_CNT_W'(LONG_MAX));

    // Stall is purely a function of current inputs and registered scoreboard state.
    assign stall_id = id_valid && ((|lu_hit) || (|raw_hit) || waw_hit || struct_hit);

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt;

    // Saturating count of cycles in which ID was held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall_id && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign stall_cycles = stall_cnt;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_fwd_scoreboard.sv
// Directed self-checking bench for hazard_fwd_scoreboard (default parameters).
module tb_hazard_fwd_scoreboard;

    localparam int AW   = 5;
    localparam int NS   = 2;
    localparam int FS   = 2;
    localparam int SELW = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               id_valid;
    logic [NS*AW-1:0]   id_rs_addr;
    logic [NS-1:0]      id_rs_used;
    logic [AW-1:0]      id_rd_addr;
    logic               id_reg_w;
    logic               id_is_long;
    logic [NS*AW-1:0]   ex_rs_addr;
    logic [AW-1:0]      ex_rd_addr;
    logic               ex_reg_w;
    logic               ex_is_load;
    logic               ex_is_long;
    logic               ex_kill;
    logic [FS*AW-1:0]   stg_rd_addr;
    logic [FS-1:0]      stg_reg_w;
    logic               lu_wb_valid;
    logic [AW-1:0]      lu_wb_rd;
    logic [NS*SELW-1:0] fwd_sel;
    logic               stall_id;
    logic               sb_err;
    logic [31:0]        stall_cycles;

    int   total = 0;
    int   bad = 0;
    int   exp_cnt = 0;
    logic cur_exp_stall = 1'b0;

    hazard_fwd_scoreboard dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs_addr   (id_rs_addr),
        .id_rs_used   (id_rs_used),
        .id_rd_addr   (id_rd_addr),
        .id_reg_w     (id_reg_w),
        .id_is_long   (id_is_long),
        .ex_rs_addr   (ex_rs_addr),
        .ex_rd_addr   (ex_rd_addr),
        .ex_reg_w     (ex_reg_w),
        .ex_is_load   (ex_is_load),
        .ex_is_long   (ex_is_long),
        .ex_kill      (ex_kill),
        .stg_rd_addr  (stg_rd_addr),
        .stg_reg_w    (stg_reg_w),
        .lu_wb_valid  (lu_wb_valid),
        .lu_wb_rd     (lu_wb_rd),
        .fwd_sel      (fwd_sel),
        .stall_id     (stall_id),
        .sb_err       (sb_err),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkStall(input string tag, input logic expected);
        cur_exp_stall = expected;
        checkOutput(tag, {31'b0, stall_id}, {31'b0, expected});
    endtask

    task automatic checkCounter(input string tag);
`ifdef HAZ_PERF_CNT_EN
        checkOutput(tag, stall_cycles, exp_cnt);
`else
        checkOutput(tag, stall_cycles, 32'd0);
`endif
    endtask

    task automatic clearAll();
        id_valid    = 1'b0;
        id_rs_addr  = '0;
        id_rs_used  = '0;
        id_rd_addr  = '0;
        id_reg_w    = 1'b0;
        id_is_long  = 1'b0;
        ex_rs_addr  = '0;
        ex_rd_addr  = '0;
        ex_reg_w    = 1'b0;
        ex_is_load  = 1'b0;
        ex_is_long  = 1'b0;
        ex_kill     = 1'b0;
        stg_rd_addr = '0;
        stg_reg_w   = '0;
        lu_wb_valid = 1'b0;
        lu_wb_rd    = '0;
        cur_exp_stall = 1'b0;
    endtask

    task automatic applyStimulus(input logic v, input logic [AW-1:0] rs1, input logic [AW-1:0] rs0,
                                 input logic [1:0] used, input logic [AW-1:0] rd,
                                 input logic regw, input logic is_long);
        id_valid   = v;
        id_rs_addr = {rs1, rs0};
        id_rs_used = used;
        id_rd_addr = rd;
        id_reg_w   = regw;
        id_is_long = is_long;
    endtask

    task automatic tick();
        @(posedge clk);
        if (cur_exp_stall && rst_n) exp_cnt++;
        #1;
    endtask

    initial begin
        clearAll();
        rst_n = 1'b0;
        #2;
        checkOutput("rst_fwd_sel", {28'b0, fwd_sel}, 32'd0);
        checkStall("rst_stall", 1'b0);
        checkOutput("rst_sb_err", {31'b0, sb_err}, 32'd0);
        checkOutput("rst_cycles", stall_cycles, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // forwarding priority
        stg_rd_addr = {5'd5, 5'd5};
        stg_reg_w   = 2'b11;
        ex_rs_addr  = {5'd9, 5'd5};
        #1 checkOutput("fwd_nearest", {28'b0, fwd_sel}, 32'h1);
        stg_reg_w = 2'b10;
        #1 checkOutput("fwd_far_only", {28'b0, fwd_sel}, 32'h2);
        stg_rd_addr = {5'd5, 5'd6};
        stg_reg_w   = 2'b11;
        ex_rs_addr  = {5'd6, 5'd5};
        #1 checkOutput("fwd_both_src", {28'b0, fwd_sel}, 32'h6);
        stg_rd_addr = '0;
        ex_rs_addr  = '0;
        #1 checkOutput("fwd_x0", {28'b0, fwd_sel}, 32'h0);
        clearAll();
        tick();

        // load-use
        ex_is_load = 1'b1;
        ex_reg_w   = 1'b1;
        ex_rd_addr = 5'd7;
        applyStimulus(1'b1, 5'd7, 5'd1, 2'b10, 5'd0, 1'b0, 1'b0);
        #1 checkStall("lu_hit", 1'b1);
        tick();
        ex_is_load = 1'b0;
        ex_reg_w   = 1'b0;
        #1 checkStall("lu_gone", 1'b0);
        ex_is_load = 1'b1;
        ex_reg_w   = 1'b1;
        id_rs_used = 2'b01;
        #1 checkStall("lu_unused", 1'b0);
        id_rs_used = 2'b11;
        ex_kill    = 1'b1;
        #1 checkStall("lu_kill", 1'b0);
        ex_kill = 1'b0;
        #1 checkStall("lu_hit_again", 1'b1);
        ex_rd_addr = 5'd0;
        id_rs_addr = '0;
        #1 checkStall("lu_x0", 1'b0);
        clearAll();
        tick();

        // long op RAW / WAW
        ex_is_long = 1'b1;
        ex_reg_w   = 1'b1;
        ex_rd_addr = 5'd9;
        tick();
        clearAll();
        applyStimulus(1'b1, 5'd0, 5'd9, 2'b01, 5'd0, 1'b0, 1'b0);
        #1 checkStall("raw_busy", 1'b1);
        tick();
        checkStall("raw_hold", 1'b1);
        applyStimulus(1'b1, 5'd0, 5'd0, 2'b00, 5'd9, 1'b1, 1'b0);
        #1 checkStall("waw_busy", 1'b1);
        applyStimulus(1'b1, 5'd0, 5'd9, 2'b01, 5'd0, 1'b0, 1'b0);
        lu_wb_valid = 1'b1;
        lu_wb_rd    = 5'd9;
        #1 checkStall("raw_wb_cycle", 1'b1);
        tick();
        lu_wb_valid = 1'b0;
        #1 checkStall("raw_release", 1'b0);
        checkOutput("raw_sb_err", {31'b0, sb_err}, 32'd0);
        clearAll();
        tick();

        // structural limit
        for (int i = 1; i <= 3; i++) begin
            ex_is_long = 1'b1;
            ex_reg_w   = 1'b1;
            ex_rd_addr = AW'(i);
            tick();
        end
        ex_rd_addr = 5'd4;
        applyStimulus(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b1);
        #1 checkStall("struct_three", 1'b0);
        tick();
        ex_is_long = 1'b0;
        ex_reg_w   = 1'b0;
        #1 checkStall("struct_full", 1'b1);
        tick();
        lu_wb_valid = 1'b1;
        lu_wb_rd    = 5'd2;
        #1 checkStall("struct_wb_cycle", 1'b1);
        tick();
        lu_wb_valid = 1'b0;
        #1 checkStall("struct_release", 1'b0);
        tick();

        // same-cycle set+clear of r3 (busy: 1,3,4; outstanding 3)
        clearAll();
        ex_is_long  = 1'b1;
        ex_reg_w    = 1'b1;
        ex_rd_addr  = 5'd3;
        lu_wb_valid = 1'b1;
        lu_wb_rd    = 5'd3;
        tick();
        clearAll();
        applyStimulus(1'b1, 5'd0, 5'd3, 2'b01, 5'd0, 1'b0, 1'b0);
        #1 checkStall("setclr_busy", 1'b1);
        applyStimulus(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b1);
        #1 checkStall("setclr_count", 1'b0);
        ex_is_long = 1'b1;
        ex_reg_w   = 1'b1;
        ex_rd_addr = 5'd5;
        tick();
        clearAll();
        applyStimulus(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b1);
        #1 checkStall("count_full_again", 1'b1);
        checkOutput("sb_err_clean", {31'b0, sb_err}, 32'd0);
        lu_wb_valid = 1'b1;
        lu_wb_rd    = 5'd6;
        tick();
        lu_wb_valid = 1'b0;
        #1 checkOutput("sb_err_set", {31'b0, sb_err}, 32'd1);
        checkStall("bad_wb_no_dec", 1'b1);
        checkCounter("cycles_before_reset");

        // reset in the middle of a stall
        applyStimulus(1'b1, 5'd0, 5'd3, 2'b01, 5'd0, 1'b0, 1'b0);
        #1 checkStall("pre_reset", 1'b1);
        rst_n   = 1'b0;
        exp_cnt = 0;
        #1 checkStall("reset_stall", 1'b0);
        checkOutput("reset_sb_err", {31'b0, sb_err}, 32'd0);
        checkCounter("reset_cycles");
        tick();
        rst_n = 1'b1;
        applyStimulus(1'b1, 5'd0, 5'd3, 2'b01, 5'd0, 1'b0, 1'b1);
        #1 checkStall("post_reset", 1'b0);
        tick();
        checkCounter("post_reset_cycles");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
